// File: rtl/code_conv_arbiter.sv
// code_conv_arbiter
// Two requesters share one 3-to-4 code converter. At most one transaction
// is outstanding. Ties are broken by a round-robin priority pointer that
// starts at PRIO_INIT after reset.
// Optional build macro ARB_STATS_EN adds per-requester saturating grant
// counters on ports grant_cnt0 / grant_cnt1.
module code_conv_arbiter #(
   parameter int unsigned PRIO_INIT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [2:0] req0_code,
   output logic       req0_ready,
   output logic       resp0_valid,
   output logic [3:0] resp0_data,
   input  logic       resp0_ready,
   input  logic       req1_valid,
   input  logic [2:0] req1_code,
   output logic       req1_ready,
   output logic       resp1_valid,
   output logic [3:0] resp1_data,
   input  logic       resp1_ready,
   output logic       busy
`ifdef ARB_STATS_EN
   ,
   output logic [7:0] grant_cnt0,
   output logic [7:0] grant_cnt1
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic PRIO_RST = (PRIO_INIT != 0);

   state_t     state_q, state_d;
   logic       prio_q, prio_d;
   logic [2:0] code_q, code_d;
   logic       grant_q, grant_d;
   logic [3:0] result_q, result_d;

   logic       any_req;
   logic       win;

   // Shared converter table
   function automatic logic [3:0] conv_map(input logic [2:0] c);
      logic [3:0] r;
      case (c)
         3'd0:    r = 4'd1;
         3'd1:    r = 4'd9;
         3'd2:    r = 4'd7;
         3'd3:    r = 4'd6;
         3'd4:    r = 4'd0;
         3'd5:    r = 4'd3;
         3'd6:    r = 4'd1;
         default: r = 4'd9;
      endcase
      return r;
   endfunction

   // Arbitration: pointer decides ties, a lone requester always wins
   always_comb begin
      any_req = req0_valid | req1_valid;
      win     = (req0_valid && req1_valid) ? prio_q : req1_valid;
   end

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         prio_q   <= PRIO_RST;
         code_q   <= '0;
         grant_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         code_q   <= code_d;
         grant_q  <= grant_d;
         result_q <= result_d;
      end
   end

   // Next-state logic and all outputs
   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      code_d      = code_q;
      grant_d     = grant_q;
      result_d    = result_q;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      resp0_valid = 1'b0;
      resp0_data  = '0;
      resp1_valid = 1'b0;
      resp1_data  = '0;
      busy        = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               req0_ready = ~win;
               req1_ready = win;
               code_d     = win ? req1_code : req0_code;
               grant_d    = win;
               prio_d     = ~win;
               state_d    = CONV;
            end
         end
         CONV: begin
            busy     = 1'b1;
            result_d = conv_map(code_q);
            state_d  = RESP;
         end
         RESP: begin
            busy = 1'b1;
            if (grant_q) begin
               resp1_valid = 1'b1;
               resp1_data  = result_q;
               if (resp1_ready) state_d = IDLE;
            end else begin
               resp0_valid = 1'b1;
               resp0_data  = result_q;
               if (resp0_ready) state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef ARB_STATS_EN
   logic [7:0] cnt0_q, cnt0_d;
   logic [7:0] cnt1_q, cnt1_d;

   // Saturating grant counters, bumped on each accept handshake
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (req0_ready && (cnt0_q != 8'hFF)) cnt0_d = cnt0_q + 8'd1;
      if (req1_ready && (cnt1_q != 8'hFF)) cnt1_d = cnt1_q + 8'd1;
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: doc/code_conv_arbiter.md
CODE_CONV_ARBITER -- requirements
Module: code_conv_arbiter

Interface
REQ-001 Parameter: PRIO_INIT, default 0, index of the requester that wins the first tie after reset (0 or 1).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: req0_valid  input  1  requester 0 presents a code.
REQ-005 Port: req0_code  input  3  requester 0 operand.
REQ-006 Port: req0_ready  output  1  requester 0 request accepted this cycle.
REQ-007 Port: resp0_valid  output  1  result for requester 0 available.
REQ-008 Port: resp0_data  output  4  converted result for requester 0.
REQ-009 Port: resp0_ready  input  1  requester 0 consumes result.
REQ-010 Ports req1_valid, req1_code, req1_ready, resp1_valid, resp1_data, resp1_ready: same directions, widths and meanings as REQ-004..009, for requester 1.
REQ-011 Port: busy  output  1  a transaction is in flight (state not IDLE).

Function
REQ-012 Block shares one internal 3-to-4 code converter between two requesters; exactly one transaction outstanding at a time.
REQ-013 Converter map (in -> out, decimal): 0->1, 1->9, 2->7, 3->6, 4->0, 5->3, 6->1, 7->9.
REQ-014 FSM states: IDLE, CONV, RESP.
REQ-015 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally that cycle, register its code and grant index, go to CONV; else stay in IDLE.
REQ-016 reqN_ready is asserted only in IDLE, only for the granted requester, and never for both in the same cycle.
REQ-017 Tie (both valid in IDLE): grant the requester held in the priority pointer; after every grant the pointer points to the other requester (round-robin).
REQ-018 Single valid request: granted regardless of pointer; pointer still updates per REQ-017.
REQ-019 CONV: register converter output of the stored code into the result register; go to RESP (exactly one cycle).
REQ-020 RESP: assert respN_valid for the granted requester only, with respN_data = stored result; the other resp valid stays 0.
REQ-021 respN_data and respN_valid hold stable in RESP until respN_ready = 1; on that cycle return to IDLE.
REQ-022 Latency: request accepted at edge N -> respN_valid high from cycle N+2; a new request can be accepted in the cycle after the response handshake at the earliest.
REQ-023 Requests arriving while busy are not accepted; reqN_ready = 0 and the request must be held by the requester.
REQ-024 respN_ready asserted outside RESP, or for the non-granted requester, is ignored.
REQ-025 respN_data for a non-granted requester or outside RESP is 4'b0000.
REQ-026 busy = 1 in CONV and RESP, 0 in IDLE.

Reset
REQ-027 rst high at a clock edge: state = IDLE, priority pointer = PRIO_INIT, stored code/result/grant = 0.
REQ-028 After reset all outputs are 0: req0/1_ready, resp0/1_valid, resp0/1_data, busy.
REQ-029 Reset asserted in CONV or RESP abandons the transaction; no response is ever delivered for it.

Configuration
REQ-030 Macro ARB_STATS_EN: when defined, adds output ports grant_cnt0 and grant_cnt1 (8 bits each), counting grants per requester, saturating at 255, cleared by rst.
REQ-031 Without ARB_STATS_EN, those ports and counters do not exist; all other behaviour is identical.

Verification
REQ-032 Reset, then req0_valid=1, code=3, resp0_ready=1 -> req0_ready high in the accept cycle, resp0_valid high 2 cycles later with data 6, back to IDLE next cycle.
REQ-033 PRIO_INIT=0, both valid (code0=1, code1=5), resp ready held high -> grants in order 0,1,0,1; responses 9, 3 alternate; no double ready.
REQ-034 req1 code=4, resp1_ready=0 for 5 cycles -> resp1_valid/data=0 held stable, busy=1, req0 not accepted; release -> handshake, IDLE.
REQ-035 Sweep codes 0..7 on requester 0 -> results 1,9,7,6,0,3,1,9.
REQ-036 rst pulsed in CONV -> all outputs 0 next cycle, no response appears, next request served normally with pointer = PRIO_INIT.
REQ-037 With ARB_STATS_EN, 300 requester-0-only grants -> grant_cnt0 = 255, grant_cnt1 = 0.
